i2s_rx: RTL

I2S_RX -- requirements
Module: i2s_rx

---
 rtl/i2s_rx_if.sv | 27 ++
 rtl/i2s_rx.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/i2s_rx_if.sv
// Stereo sample output channel of the I2S receiver.
// The master presents a captured left/right pair; the slave accepts it with out_ready.
interface i2s_rx_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] left_data;
    logic [DATA_WIDTH-1:0] right_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  overrun;

    modport master (
        output left_data,
        output right_data,
        output out_valid,
        output overrun,
        input  out_ready
    );

    modport slave (
        input  left_data,
        input  right_data,
        input  out_valid,
        input  overrun,
        output out_ready
    );
endinterface

// File: rtl/i2s_rx.sv
// I2S master receiver: generates BCLK/LRCLK, captures MSB-first words with the
// one-bit I2S delay and presents them as stereo pairs over a valid/ready channel.
module i2s_rx #(
    parameter int DATA_WIDTH = 16,   // >= 2
    parameter int SLOT_BITS  = 32,   // >= DATA_WIDTH+1
    parameter int CLK_DIV    = 2     // >= 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    input  logic        i2s_sdin,
    i2s_rx_if.master    pair_if
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2(SLOT_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_BITS - 1);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_WIDTH);

    logic [DIV_W-1:0]      div_q,        div_d;
    logic                  bclk_q,       bclk_d;
    logic                  lrclk_q,      lrclk_d;
    logic [CNT_W-1:0]      bit_cnt_q,    bit_cnt_d;
    logic [DATA_WIDTH-1:0] shl_q,        shl_d;
    logic [DATA_WIDTH-1:0] shr_q,        shr_d;
    logic                  left_ok_q,    left_ok_d;
    logic                  pair_pend_q,  pair_pend_d;
    logic [DATA_WIDTH-1:0] left_data_q,  left_data_d;
    logic [DATA_WIDTH-1:0] right_data_q, right_data_d;
    logic                  valid_q,      valid_d;
    logic                  overrun_q,    overrun_d;

    logic tick, rise, fall, in_word, last_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q        <= '0;
            bclk_q       <= 1'b0;
            lrclk_q      <= 1'b0;
            bit_cnt_q    <= '0;
            shl_q        <= '0;
            shr_q        <= '0;
            left_ok_q    <= 1'b0;
            pair_pend_q  <= 1'b0;
            left_data_q  <= '0;
            right_data_q <= '0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            div_q        <= div_d;
            bclk_q       <= bclk_d;
            lrclk_q      <= lrclk_d;
            bit_cnt_q    <= bit_cnt_d;
            shl_q        <= shl_d;
            shr_q        <= shr_d;
            left_ok_q    <= left_ok_d;
            pair_pend_q  <= pair_pend_d;
            left_data_q  <= left_data_d;
            right_data_q <= right_data_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign tick     = (div_q == DIV_LAST);
    assign rise     = en && tick && !bclk_q;
    assign fall     = en && tick && bclk_q;
    assign in_word  = (bit_cnt_q != '0) && (bit_cnt_q <= WORD_LAST);
    assign last_bit = (bit_cnt_q == WORD_LAST);

    // Bit clock, slot counter and word capture.
    always_comb begin
        div_d       = div_q;
        bclk_d      = bclk_q;
        lrclk_d     = lrclk_q;
        bit_cnt_d   = bit_cnt_q;
        shl_d       = shl_q;
        shr_d       = shr_q;
        left_ok_d   = left_ok_q;
        pair_pend_d = 1'b0;

        if (!en) begin
            div_d     = '0;
            bclk_d    = 1'b0;
            lrclk_d   = 1'b0;
            bit_cnt_d = '0;
            left_ok_d = 1'b0;
        end else begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) begin
                bclk_d = !bclk_q;
            end
            if (fall) begin
                if (bit_cnt_q == SLOT_LAST) begin
                    bit_cnt_d = '0;
                    lrclk_d   = !lrclk_q;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            if (rise && in_word) begin
                if (lrclk_q) begin
                    shr_d = {shr_q[DATA_WIDTH-2:0], i2s_sdin};
                end else begin
                    shl_d = {shl_q[DATA_WIDTH-2:0], i2s_sdin};
                end
                if (last_bit) begin
                    if (!lrclk_q) begin
                        left_ok_d = 1'b1;
                    end else if (left_ok_q) begin
                        left_ok_d   = 1'b0;
                        pair_pend_d = 1'b1;
                    end
                end
            end
        end
    end

    // Output channel; a completed pair is offered one clk after the final rise.
    always_comb begin
        left_data_d  = left_data_q;
        right_data_d = right_data_q;
        valid_d      = valid_q;
        overrun_d    = 1'b0;

        if (valid_q && pair_if.out_ready) begin
            valid_d = 1'b0;
        end
        if (pair_pend_q) begin
            if (!valid_q || pair_if.out_ready) begin
                left_data_d  = shl_q;
                right_data_d = shr_q;
                valid_d      = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign i2s_bclk           = bclk_q;
    assign i2s_lrclk          = lrclk_q;
    assign pair_if.left_data  = left_data_q;
    assign pair_if.right_data = right_data_q;
    assign pair_if.out_valid  = valid_q;
    assign pair_if.overrun    = overrun_q;
endmodule
